// File: rtl/dino_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dino_pkg
//  Purpose  : Shared types and constants for the Dino Run obstacle engine:
//             game states, LFSR geometry/seed, obstacle descriptor and small
//             helper functions used by the engine and its lane slices.
//  Ports    : (package, none)
//  Revision : 1.0  initial release
// ============================================================================
package dino_pkg;

  typedef enum logic [0:0] {RUN = 1'b0, OVER = 1'b1} state_e;

  // State encodings used by the registered FSM.
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_OVER = 1'b1;

  // 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1 -> taps on bits 7,5,4,3.
  localparam int              LFSR_W    = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;

  localparam int OBS_XW = 11;

  typedef struct packed {
    logic [OBS_XW-1:0] x;
    logic [OBS_XW-1:0] y;
    logic [7:0]        w;
    logic [7:0]        h;
  } obs_t;

  // Shift left, feedback XOR of the tapped bits enters at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

  // Rotate a 6-bit value left by k (mod 6); fixed loop bound keeps it synthesizable.
  function automatic logic [5:0] rot6(input logic [5:0] v, input int k);
    logic [5:0] r;
    r = v;
    for (int j = 0; j < 6; j++) begin
      if (j < (k % 6)) r = {r[4:0], r[5]};
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/obstacle_lane.sv
`default_nettype none
// ============================================================================
//  Module   : obstacle_lane
//  Purpose  : One obstacle lane: holds the lane x register, steps it left by
//             the current speed on each motion tick or respawns it beyond the
//             right edge, and reports the player/obstacle box overlap.
//  Ports    : clk, reset        clock, async active-high reset
//             restart_i         reload the initial x (replay)
//             step_i            motion tick for this cycle
//             speed_i           pixels per tick
//             lfsr_i            low 6 bits of the pre-advance LFSR
//             player_*_i        player box
//             obs_y/w/h_i       this lane's static box geometry
//             x_o               lane left x
//             passed_o          lane would respawn on a step this cycle
//             hit_o             player box overlaps this lane's box
//  Revision : 1.0  initial release
// ============================================================================
module obstacle_lane
  import dino_pkg::*;
#(
  parameter int            XW       = 11,
  parameter int            LANE     = 0,
  parameter logic [XW-1:0] INIT_X   = '0,
  parameter int            SCREEN_W = 1280,
  parameter int            MIN_GAP  = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart_i,
  input  logic          step_i,
  input  logic [3:0]    speed_i,
  input  logic [5:0]    lfsr_i,
  input  logic [XW-1:0] player_x_i,
  input  logic [XW-1:0] player_y_i,
  input  logic [7:0]    player_w_i,
  input  logic [7:0]    player_h_i,
  input  logic [XW-1:0] obs_y_i,
  input  logic [7:0]    obs_w_i,
  input  logic [7:0]    obs_h_i,
  output logic [XW-1:0] x_o,
  output logic          passed_o,
  output logic          hit_o
);

  localparam int            SW         = XW + 1;
  localparam logic [XW-1:0] SPAWN_BASE = XW'(SCREEN_W + MIN_GAP);

  logic [XW-1:0] x_q, x_d;
  logic [5:0]    w_rnd;
  logic [XW-1:0] w_respawn;
  logic [XW:0]   w_ox_end, w_oy_end, w_px_end, w_py_end;

  // Each lane sees a different rotation of the shared random bits so that
  // simultaneous respawns do not land on top of each other.
  assign w_rnd     = rot6(lfsr_i, LANE);
  // Respawn position wraps modulo 2^XW by design of the coordinate width.
  assign w_respawn = SPAWN_BASE + XW'({w_rnd, 4'b0000});
  assign passed_o  = (x_q <= XW'(speed_i));

  always_comb begin
    x_d = x_q;
    if (restart_i)   x_d = INIT_X;
    else if (step_i) x_d = passed_o ? w_respawn : (x_q - XW'(speed_i));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) x_q <= INIT_X;
    else       x_q <= x_d;
  end

  // One extra bit on every edge sum so box ends never wrap.
  assign w_ox_end = {1'b0, x_q}        + SW'(obs_w_i);
  assign w_oy_end = {1'b0, obs_y_i}    + SW'(obs_h_i);
  assign w_px_end = {1'b0, player_x_i} + SW'(player_w_i);
  assign w_py_end = {1'b0, player_y_i} + SW'(player_h_i);

  assign hit_o = ({1'b0, player_x_i} < w_ox_end) && (w_px_end > {1'b0, x_q}) &&
                 ({1'b0, player_y_i} < w_oy_end) && (w_py_end > {1'b0, obs_y_i});

  assign x_o = x_q;

endmodule
`default_nettype wire

// File: rtl/obstacle_engine.sv
`default_nettype none
// ============================================================================
//  Module   : obstacle_engine
//  Purpose  : Dino Run game core. Shared motion-tick timer, LFSR, score and
//             pass/level accounting, speed ramp, RUN/OVER state machine with
//             replay edge detection; NUM_OBS obstacle_lane slices do motion
//             and collision per lane.
//  Ports    : clk, reset              clock, async active-high reset
//             replay_btn              replay button level
//             player_x/y, player_w/h  player box
//             obs_y, obs_w, obs_h     packed per-lane static geometry
//             obs_x                   packed per-lane left x
//             game_over               high in OVER
//             speed                   pixels per tick
//             score                   saturating pass count
//             tick                    one-cycle motion update pulse
//             anim_phase              sprite animation phase
//  Revision : 1.0  initial release
// ============================================================================
module obstacle_engine
  import dino_pkg::*;
#(
  parameter int NUM_OBS        = 4,
  parameter int XW             = 11,
  parameter int SCREEN_W       = 1280,
  parameter int SPAWN_STRIDE   = 200,
  parameter int TICK_CYCLES    = 2_000_000,
  parameter int PASS_PER_LEVEL = 12,
  parameter int MAX_SPEED      = 8,
  parameter int MIN_GAP        = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  replay_btn,
  input  logic [XW-1:0]         player_x,
  input  logic [XW-1:0]         player_y,
  input  logic [7:0]            player_w,
  input  logic [7:0]            player_h,
  input  logic [NUM_OBS*XW-1:0] obs_y,
  input  logic [NUM_OBS*8-1:0]  obs_w,
  input  logic [NUM_OBS*8-1:0]  obs_h,
  output logic [NUM_OBS*XW-1:0] obs_x,
  output logic                  game_over,
  output logic [3:0]            speed,
  output logic [15:0]           score,
  output logic                  tick,
  output logic [1:0]            anim_phase
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int PW = $clog2(PASS_PER_LEVEL + NUM_OBS + 1) + 1;

  logic [0:0]        state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [3:0]        speed_q, speed_d;
  logic [15:0]       score_q, score_d;
  logic [PW-1:0]     pass_q, pass_d;
  logic [1:0]        phase_q, phase_d;
  logic              tick_q, tick_d;
  logic              btn_q;

  logic               w_run, w_tc, w_step, w_restart;
  logic [NUM_OBS-1:0] w_passed, w_hit;
  logic [3:0]         w_npass;
  logic [16:0]        w_score_sum;
  logic [PW-1:0]      w_pass_sum;

  assign w_run     = (state_q == ST_RUN);
  assign w_tc      = (timer_q == TW'(TICK_CYCLES - 1));
  assign w_step    = w_run & w_tc;
  // Edge against the registered previous sample: a button already held when
  // the collision happens does not count as a press.
  assign w_restart = ~w_run & replay_btn & ~btn_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OBS; gi++) begin : g_lane
      obstacle_lane #(
        .XW       (XW),
        .LANE     (gi),
        .INIT_X   (XW'(SCREEN_W - 80 + gi * SPAWN_STRIDE)),
        .SCREEN_W (SCREEN_W),
        .MIN_GAP  (MIN_GAP)
      ) u_lane (
        .clk        (clk),
        .reset      (reset),
        .restart_i  (w_restart),
        .step_i     (w_step),
        .speed_i    (speed_q),
        .lfsr_i     (lfsr_q[5:0]),
        .player_x_i (player_x),
        .player_y_i (player_y),
        .player_w_i (player_w),
        .player_h_i (player_h),
        .obs_y_i    (obs_y[gi*XW +: XW]),
        .obs_w_i    (obs_w[gi*8 +: 8]),
        .obs_h_i    (obs_h[gi*8 +: 8]),
        .x_o        (obs_x[gi*XW +: XW]),
        .passed_o   (w_passed[gi]),
        .hit_o      (w_hit[gi])
      );
    end
  endgenerate

  // Simultaneous respawns each count as a pass.
  always_comb begin
    w_npass = '0;
    for (int i = 0; i < NUM_OBS; i++) w_npass = w_npass + 4'(w_passed[i]);
  end

  assign w_score_sum = {1'b0, score_q} + 17'(w_npass);
  assign w_pass_sum  = pass_q + PW'(w_npass);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    lfsr_d  = lfsr_q;
    speed_d = speed_q;
    score_d = score_q;
    pass_d  = pass_q;
    phase_d = phase_q;
    tick_d  = 1'b0;
    if (w_run) begin
      if (w_tc) begin
        timer_d = '0;
        tick_d  = 1'b1;
        lfsr_d  = lfsr_next(lfsr_q);
        phase_d = phase_q + 2'd1;
        score_d = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
        if (w_pass_sum >= PW'(PASS_PER_LEVEL)) begin
          pass_d  = w_pass_sum - PW'(PASS_PER_LEVEL);
          speed_d = (speed_q >= 4'(MAX_SPEED)) ? 4'(MAX_SPEED) : speed_q + 4'd1;
        end else begin
          pass_d  = w_pass_sum;
        end
      end else begin
        timer_d = timer_q + TW'(1);
      end
      // The tick update above still lands when a hit coincides with it.
      if (|w_hit) state_d = ST_OVER;
    end else if (w_restart) begin
      state_d = ST_RUN;
      timer_d = '0;
      speed_d = 4'd1;
      score_d = '0;
      pass_d  = '0;
      phase_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      timer_q <= '0;
      lfsr_q  <= LFSR_SEED;
      speed_q <= 4'd1;
      score_q <= '0;
      pass_q  <= '0;
      phase_q <= '0;
      tick_q  <= 1'b0;
      btn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      lfsr_q  <= lfsr_d;
      speed_q <= speed_d;
      score_q <= score_d;
      pass_q  <= pass_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
      btn_q   <= replay_btn;
    end
  end

  assign game_over  = (state_q == ST_OVER);
  assign speed      = speed_q;
  assign score      = score_q;
  assign tick       = tick_q;
  assign anim_phase = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_obstacle_engine
//  Purpose  : Self-checking bench for obstacle_engine. A behavioural game
//             model pushes the expected outputs for every tick / state change
//             into a queue; a negedge monitor pops and compares whenever the
//             DUT pulses tick or changes game_over. Directed checks cover
//             reset, first tick, speed ramp, collision, replay and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_obstacle_engine;

  localparam int NUM_OBS = 4;
  localparam int XW      = 11;
  localparam int TC      = 4;
  localparam int SCR_W   = 1280;
  localparam int STRIDE  = 200;
  localparam int PPL     = 12;
  localparam int MAXS    = 8;
  localparam int GAP     = 64;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  replay_btn = 1'b0;
  logic [XW-1:0]         player_x = 11'd100;
  logic [XW-1:0]         player_y = 11'd248;
  logic [7:0]            player_w = 8'd32;
  logic [7:0]            player_h = 8'd32;
  logic [NUM_OBS*XW-1:0] obs_y = {11'd100, 11'd248, 11'd248, 11'd248};
  logic [NUM_OBS*8-1:0]  obs_w = {4{8'd32}};
  logic [NUM_OBS*8-1:0]  obs_h = {4{8'd32}};
  logic [NUM_OBS*XW-1:0] obs_x;
  logic                  game_over;
  logic [3:0]            speed;
  logic [15:0]           score;
  logic                  tick;
  logic [1:0]            anim_phase;

  always #5 clk = ~clk;

  obstacle_engine #(
    .NUM_OBS(NUM_OBS), .XW(XW), .SCREEN_W(SCR_W), .SPAWN_STRIDE(STRIDE),
    .TICK_CYCLES(TC), .PASS_PER_LEVEL(PPL), .MAX_SPEED(MAXS), .MIN_GAP(GAP)
  ) dut (
    .clk(clk), .reset(reset), .replay_btn(replay_btn),
    .player_x(player_x), .player_y(player_y), .player_w(player_w), .player_h(player_h),
    .obs_y(obs_y), .obs_w(obs_w), .obs_h(obs_h),
    .obs_x(obs_x), .game_over(game_over), .speed(speed), .score(score),
    .tick(tick), .anim_phase(anim_phase)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [NUM_OBS*XW-1:0] x;
    logic [15:0]           sc;
    logic [3:0]            sp;
    logic [1:0]            ph;
    logic                  go;
    logic                  tk;
  } rec_t;

  rec_t q[$];

  int         m_x[NUM_OBS];
  int         m_speed, m_score, m_pass, m_timer, m_phase;
  logic [7:0] m_lfsr;
  bit         m_over, m_prev;

  function automatic int init_x(input int i);
    return SCR_W - 80 + i * STRIDE;
  endfunction

  function automatic int lane_y(input int i);
    return (i == 3) ? 100 : 248;
  endfunction

  function automatic int rot(input int v, input int i);
    int k;
    k = i % 6;
    return ((v << k) | (v >> (6 - k))) & 63;
  endfunction

  function automatic bit m_hit(input int i);
    int px, py, pw, ph;
    px = int'(player_x); py = int'(player_y); pw = int'(player_w); ph = int'(player_h);
    return (px < m_x[i] + 32) && (px + pw > m_x[i]) &&
           (py < lane_y(i) + 32) && (py + ph > lane_y(i));
  endfunction

  function automatic logic [NUM_OBS*XW-1:0] pack_x();
    logic [NUM_OBS*XW-1:0] v;
    for (int i = 0; i < NUM_OBS; i++) v[i*XW +: XW] = XW'(m_x[i]);
    return v;
  endfunction

  task automatic m_restore();
    for (int i = 0; i < NUM_OBS; i++) m_x[i] = init_x(i);
    m_speed = 1; m_score = 0; m_pass = 0; m_timer = 0; m_phase = 0; m_over = 0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_restore();
      m_lfsr = 8'hA5;
      m_prev = 0;
    end else begin
      bit   hit, tk, was_over, rise;
      int   n;
      rec_t r;
      was_over = m_over;
      tk = 0; hit = 0; n = 0;
      rise = replay_btn && !m_prev;
      m_prev = replay_btn;
      if (!m_over) begin
        for (int i = 0; i < NUM_OBS; i++) if (m_hit(i)) hit = 1;
        if (m_timer == TC - 1) begin
          tk = 1;
          m_timer = 0;
          for (int i = 0; i < NUM_OBS; i++) begin
            if (m_x[i] <= m_speed) begin
              m_x[i] = (SCR_W + GAP + 16 * rot(int'(m_lfsr[5:0]), i)) % (1 << XW);
              n++;
            end else begin
              m_x[i] = m_x[i] - m_speed;
            end
          end
          m_lfsr  = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
          m_phase = (m_phase + 1) % 4;
          m_score = (m_score + n > 65535) ? 65535 : m_score + n;
          m_pass  = m_pass + n;
          if (m_pass >= PPL) begin
            m_pass = m_pass - PPL;
            if (m_speed < MAXS) m_speed++;
          end
        end else begin
          m_timer++;
        end
        if (hit) m_over = 1;
      end else if (rise) begin
        m_restore();
      end
      if (tk || (m_over != was_over)) begin
        r.x = pack_x(); r.sc = 16'(m_score); r.sp = 4'(m_speed);
        r.ph = 2'(m_phase); r.go = m_over; r.tk = tk;
        q.push_back(r);
      end
    end
  end

  // ---------------- monitor ----------------
  logic last_go = 1'b0;
  int   dut_ticks = 0;

  always @(negedge clk) begin
    rec_t r;
    if (!reset) begin
      if (tick || (game_over !== last_go)) begin
        if (q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL event_unexpected: got tick=%b go=%b, expected no event", tick, game_over);
        end else begin
          r = q.pop_front();
          n_checks++;
          if (tick !== r.tk || game_over !== r.go || obs_x !== r.x || score !== r.sc ||
              speed !== r.sp || anim_phase !== r.ph) begin
            n_errors++;
            $display("FAIL event: got x=%h sc=%0d sp=%0d ph=%0d go=%b tk=%b, expected x=%h sc=%0d sp=%0d ph=%0d go=%b tk=%b",
                     obs_x, score, speed, anim_phase, game_over, tick,
                     r.x, r.sc, r.sp, r.ph, r.go, r.tk);
          end
        end
      end
      if (q.size() != 0) begin
        n_checks++; n_errors++;
        $display("FAIL event_missing: got no event, expected tk=%b go=%b", q[0].tk, q[0].go);
        q.delete();
      end
      if (tick) dut_ticks++;
    end
    last_go = game_over;
  end

  // ---------------- directed sequence ----------------
  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < NUM_OBS; i++)
      chk($sformatf("%s_x%0d", tag, i), 64'(obs_x[i*XW +: XW]), 64'(init_x(i)));
    chk({tag, "_speed"}, 64'(speed), 64'd1);
    chk({tag, "_score"}, 64'(score), 64'd0);
    chk({tag, "_tick"},  64'(tick), 64'd0);
    chk({tag, "_phase"}, 64'(anim_phase), 64'd0);
    chk({tag, "_go"},    64'(game_over), 64'd0);
  endtask

  task automatic run_until_speed(input int target, input int budget);
    int k = 0;
    while (m_speed < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("speed_reach_%0d", target), 64'(speed), 64'(target));
  endtask

  function automatic bit lane_clear(input int i);
    return (m_x[i] >= 20 && m_x[i] <= 68) || (m_x[i] >= 200);
  endfunction

  initial begin
    int k, s0, t0;
    bit found;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // First tick after reset.
    k = 0;
    do begin @(negedge clk); k++; end while (!tick && k < 20);
    chk("first_tick_seen", 64'(tick), 64'd1);
    for (int i = 0; i < NUM_OBS; i++)
      chk($sformatf("first_tick_x%0d", i), 64'(obs_x[i*XW +: XW]), 64'(init_x(i) - 1));
    chk("first_tick_phase", 64'(anim_phase), 64'd1);
    chk("first_tick_speed", 64'(speed), 64'd1);
    repeat (2) @(negedge clk);
    chk("tick_single_cycle", 64'(tick), 64'd0);
    chk("tick_count", 64'(dut_ticks), 64'd1);

    // Move the player out of every lane and let the lanes cycle.
    player_y = 11'd0;
    run_until_speed(2, 30000);
    run_until_speed(MAXS, 70000);
    s0 = m_score;
    k = 0;
    while (m_score < s0 + 13 && k < 10000) begin @(negedge clk); k++; end
    chk("speed_saturated", 64'(speed), 64'(MAXS));

    // Lane 3 crosses x=100 at its own height while the player sits at y=248.
    found = 0;
    for (int j = 0; j < 30000 && !found; j++) begin
      @(negedge clk);
      if (m_x[3] >= 100 && m_x[3] <= 131 && lane_clear(0) && lane_clear(1) && lane_clear(2))
        found = 1;
    end
    chk("lane3_window_found", 64'(found), 64'd1);
    if (found) begin
      player_y = 11'd248;
      repeat (8) begin
        @(negedge clk);
        chk("lane3_no_hit", 64'(game_over), 64'd0);
      end
      player_y = 11'd0;
    end

    // Collision with the button already held.
    @(negedge clk);
    replay_btn = 1'b1;
    player_y   = 11'd248;
    k = 0;
    while (!game_over && k < 5000) begin @(negedge clk); k++; end
    chk("collision_go", 64'(game_over), 64'd1);
    t0 = dut_ticks;
    repeat (100) @(negedge clk);
    chk("over_held_btn_go", 64'(game_over), 64'd1);
    chk("over_no_ticks", 64'(dut_ticks - t0), 64'd0);
    chk("over_score_frozen", 64'(score), 64'(m_score));
    for (int i = 0; i < NUM_OBS; i++)
      chk($sformatf("over_x%0d_frozen", i), 64'(obs_x[i*XW +: XW]), 64'(m_x[i]));

    // Release, then press: back to RUN one cycle later.
    replay_btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("over_after_release", 64'(game_over), 64'd1);
    replay_btn = 1'b1;
    @(negedge clk);
    check_reset_outputs("replay");
    replay_btn = 1'b0;
    player_y   = 11'd0;

    // First respawn after replay uses the un-reset LFSR (checked by monitor).
    k = 0;
    while (m_score < 1 && k < 8000) begin @(negedge clk); k++; end
    chk("replay_first_pass", 64'(score), 64'(m_score));

    // Asynchronous reset landing in a tick cycle.
    k = 0;
    while (m_timer != TC - 1 && k < 10) begin @(negedge clk); k++; end
    chk("pre_reset_timer", 64'(m_timer), 64'(TC - 1));
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
